// File: rtl/sck_slave_control.sv
// SPI slave front end: oversamples SCK/SS_n/MOSI on clk, shifts a frame in from MOSI and out on MISO,
// with a one-deep TX holding buffer, an RX valid strobe and underrun reporting.
module sck_slave_control #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCK_in,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  LSBFE,
  input  logic [DATA_WIDTH-1:0] TX_data,
  input  logic                  TX_load,
  output logic                  TX_ready,
  output logic                  MISO,
  output logic                  MISO_oe,
  output logic [DATA_WIDTH-1:0] RX_data,
  output logic                  RX_valid,
  output logic                  underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_prev;
  logic                   sck_s, ss_s, mosi_s;
  logic                   leading, trailing, sample, shift_edge;

  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n, rx_word;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
  logic [DATA_WIDTH-1:0] tx_buf, tx_buf_n;
  logic [DATA_WIDTH-1:0] rx_data_n;
  logic                  ready_n, rx_valid_n, underrun_n;
  logic                  first_lead, first_n;
  logic                  reload;

  // SCK is synchronized polarity-normalized (SCK ^ CPOL), so the reset value 0 means "SCK at CPOL"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK_in ^ CPOL};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ss_s       = ss_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign leading    = sck_s & ~sck_prev;
  assign trailing   = ~sck_s & sck_prev;
  assign sample     = CPHA ? trailing : leading;
  assign shift_edge = CPHA ? leading : trailing;
  assign rx_word    = LSBFE ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                            : {rx_shift[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      tx_buf     <= '0;
      first_lead <= 1'b0;
      TX_ready   <= 1'b1;
      RX_data    <= '0;
      RX_valid   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      rx_shift   <= rx_shift_n;
      tx_shift   <= tx_shift_n;
      tx_buf     <= tx_buf_n;
      first_lead <= first_n;
      TX_ready   <= ready_n;
      RX_data    <= rx_data_n;
      RX_valid   <= rx_valid_n;
      underrun   <= underrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    rx_shift_n = rx_shift;
    tx_shift_n = tx_shift;
    tx_buf_n   = tx_buf;
    first_n    = first_lead;
    ready_n    = TX_ready;
    rx_data_n  = RX_data;
    rx_valid_n = 1'b0;
    underrun_n = 1'b0;
    reload     = 1'b0;

    case (state)
      IDLE: begin
        if (!ss_s) begin
          state_n   = ACTIVE;
          bit_cnt_n = '0;
          first_n   = 1'b1;
          reload    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_n   = IDLE;
          bit_cnt_n = '0;
        end else begin
          if (sample) begin
            rx_shift_n = rx_word;
            if (bit_cnt == LAST) begin
              bit_cnt_n  = '0;
              rx_data_n  = rx_word;
              rx_valid_n = 1'b1;
              if (CPHA) begin
                reload  = 1'b1;
                first_n = 1'b1;
              end
            end else begin
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end
          // CPHA=0 frame boundary: the trailing edge seen with bit_cnt already wrapped to 0
          if (shift_edge) begin
            if (CPHA && first_lead) begin
              first_n = 1'b0;
            end else if (!CPHA && bit_cnt == '0) begin
              reload = 1'b1;
            end else begin
              tx_shift_n = LSBFE ? {1'b0, tx_shift[DATA_WIDTH-1:1]}
                                 : {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (reload) begin
      if (!TX_ready) begin
        tx_shift_n = tx_buf;
        ready_n    = 1'b1;
      end else begin
        tx_shift_n = '1;
        underrun_n = 1'b1;
      end
    end

    // A same-cycle load lands after the reload has taken the old buffer content
    if (TX_load && TX_ready) begin
      tx_buf_n = TX_data;
      ready_n  = 1'b0;
    end
  end

  assign MISO_oe = ~ss_s;
  assign MISO    = MISO_oe & (LSBFE ? tx_shift[0] : tx_shift[DATA_WIDTH-1]);
  assign busy    = (state == ACTIVE);

endmodule

// File: tb/tb_sck_slave_control.sv
// Bench for sck_slave_control: an SPI master drives frames; a frame-level model predicts MISO/RX/underrun.
module tb_sck_slave_control;
  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst, SCK_in, SS_n, MOSI, CPOL, CPHA, LSBFE, TX_load;
  logic [W-1:0] TX_data, RX_data;
  logic         TX_ready, MISO, MISO_oe, RX_valid, underrun, busy;

  always #5 clk = ~clk;

  sck_slave_control #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .SCK_in(SCK_in), .SS_n(SS_n), .MOSI(MOSI),
    .CPOL(CPOL), .CPHA(CPHA), .LSBFE(LSBFE), .TX_data(TX_data), .TX_load(TX_load),
    .TX_ready(TX_ready), .MISO(MISO), .MISO_oe(MISO_oe), .RX_data(RX_data),
    .RX_valid(RX_valid), .underrun(underrun), .busy(busy)
  );

  int checks = 0, errors = 0;

  // Pulse monitors
  int   rv_cnt = 0, rv_long = 0, ur_cnt = 0, ur_long = 0;
  logic rv_prev = 1'b0, ur_prev = 1'b0;
  always @(negedge clk) begin
    if (RX_valid) begin rv_cnt++; if (rv_prev) rv_long++; end
    if (underrun) begin ur_cnt++; if (ur_prev) ur_long++; end
    rv_prev = RX_valid;
    ur_prev = underrun;
  end

  // Frame-level reference model
  logic         m_full = 1'b0;
  logic [W-1:0] m_buf = '0, m_rx = '0, cur_tx = '0;
  int           m_rv = 0, m_ur = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic take_word(output logic [W-1:0] w);
    if (m_full) begin w = m_buf; m_full = 1'b0; end
    else begin w = '1; m_ur++; end
  endtask

  task automatic model_load(input logic [W-1:0] d);
    if (!m_full) begin m_buf = d; m_full = 1'b1; end
  endtask

  task automatic load(input logic [W-1:0] d);
    TX_data = d; TX_load = 1'b1;
    tick(1);
    TX_load = 1'b0;
    model_load(d);
  endtask

  task automatic half(input bit ld, input logic [W-1:0] v);
    if (ld) begin
      TX_data = v; TX_load = 1'b1;
      tick(1);
      TX_load = 1'b0;
      model_load(v);
      tick(3);
    end else tick(4);
  endtask

  task automatic set_mode(input bit cpol, input bit cpha, input bit lsbfe);
    CPOL = cpol; CPHA = cpha; LSBFE = lsbfe; SCK_in = cpol;
    tick(4);
  endtask

  task automatic ss_fall();
    SS_n = 1'b0;
    take_word(cur_tx);
    tick(6);
    check("busy_on", busy, 1);
    check("oe_on", MISO_oe, 1);
    check("ready_after_fall", TX_ready, !m_full);
    check("underrun_cnt_fall", ur_cnt, m_ur);
  endtask

  task automatic ss_rise();
    SS_n = 1'b1;
    tick(6);
    check("busy_off", busy, 0);
    check("oe_off", MISO_oe, 0);
    check("miso_gated", MISO, 0);
    check("underrun_cnt_rise", ur_cnt, m_ur);
    check("rx_valid_cnt_rise", rv_cnt, m_rv);
  endtask

  // Master side of one frame; nbits < W aborts mid-frame without touching the model
  task automatic frame(input logic [W-1:0] rxw, input bit ld, input logic [W-1:0] ldv, input int nbits);
    logic [W-1:0] misow, exp_tx;
    int           idx;
    misow  = '0;
    exp_tx = cur_tx;
    if (!CPHA) begin
      MOSI = LSBFE ? rxw[0] : rxw[W-1];
      tick(2);
    end
    for (int i = 0; i < nbits; i++) begin
      idx = LSBFE ? i : W - 1 - i;
      if (!CPHA) begin
        misow[idx] = MISO;
        SCK_in = ~CPOL;
        half(ld && i == 3, ldv);
        SCK_in = CPOL;
        if (i < W - 1) MOSI = LSBFE ? rxw[i+1] : rxw[W-2-i];
        half(1'b0, '0);
      end else begin
        SCK_in = ~CPOL;
        MOSI = rxw[idx];
        half(ld && i == 3, ldv);
        misow[idx] = MISO;
        SCK_in = CPOL;
        half(1'b0, '0);
      end
    end
    if (nbits == W) begin
      m_rx = rxw;
      m_rv++;
      take_word(cur_tx);
      check("miso_frame", misow, exp_tx);
      check("rx_data", RX_data, m_rx);
      check("rx_valid_cnt", rv_cnt, m_rv);
      check("ready_frame_end", TX_ready, !m_full);
    end
  endtask

  int ur_before;

  initial begin
    rst = 1'b1; SCK_in = 1'b0; SS_n = 1'b1; MOSI = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
    LSBFE = 1'b0; TX_load = 1'b0; TX_data = '0;
    tick(3);
    check("rst_ready", TX_ready, 1);
    check("rst_miso", MISO, 0);
    check("rst_oe", MISO_oe, 0);
    check("rst_rx_data", RX_data, 0);
    check("rst_rx_valid", RX_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    // Mode 0, MSB first
    set_mode(0, 0, 0);
    load(8'hA5);
    check("ready_after_load", TX_ready, 0);
    ss_fall();
    frame(8'h3C, 1'b0, '0, W);
    ss_rise();

    // Mode 3, LSB first
    set_mode(1, 1, 1);
    load(8'h81);
    ss_fall();
    frame(8'h0F, 1'b0, '0, W);
    ss_rise();

    // Mode 1 back-to-back, buffer refilled during each frame
    set_mode(0, 1, 0);
    load(8'h11);
    ur_before = ur_cnt;
    ss_fall();
    frame(8'h6B, 1'b1, 8'h22, W);
    frame(8'hD4, 1'b1, 8'h33, W);
    check("b2b_no_underrun", ur_cnt, ur_before);
    ss_rise();

    // Underrun: frame starts with the buffer empty
    set_mode(0, 0, 0);
    ur_before = ur_cnt;
    ss_fall();
    check("underrun_pulse", ur_cnt, ur_before + 1);
    frame(8'h96, 1'b0, '0, W);
    ss_rise();

    // Abort after 5 bits, then a full frame
    load(8'h3E);
    ss_fall();
    frame(8'hFF, 1'b0, '0, 5);
    ss_rise();
    check("abort_rx_data", RX_data, m_rx);
    check("abort_ready", TX_ready, !m_full);
    ss_fall();
    frame(8'h5A, 1'b0, '0, W);
    ss_rise();

    // Reset mid-frame
    load(8'h47);
    ss_fall();
    frame(8'h00, 1'b0, '0, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", TX_ready, 1);
    check("mid_rst_miso", MISO, 0);
    check("mid_rst_oe", MISO_oe, 0);
    check("mid_rst_rx_data", RX_data, 0);
    check("mid_rst_rx_valid", RX_valid, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_busy", busy, 0);
    m_full = 1'b0; m_rx = '0;
    SS_n = 1'b1; SCK_in = CPOL; MOSI = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    load(8'h5C);
    ss_fall();
    frame(8'hC3, 1'b0, '0, W);
    ss_rise();

    // Randomized modes, payloads and buffer usage
    for (int k = 0; k < 12; k++) begin
      int nf;
      set_mode(1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(3) != 0) load(W'($urandom));
      ss_fall();
      nf = 1 + $urandom_range(1);
      for (int f = 0; f < nf; f++)
        frame(W'($urandom), 1'($urandom), W'($urandom), W);
      ss_rise();
    end

    check("rx_valid_one_cycle", rv_long, 0);
    check("underrun_one_cycle", ur_long, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sck_slave_control.md
Name: sck_slave_control

Overview:
Slave-side counterpart to the master SCK generator. The block oversamples the incoming SCK, SS_n and MOSI pins on the system clock and detects SCK sample and shift edges for all four CPOL/CPHA modes. It shifts a byte in from MOSI and drives a byte out on MISO. It also provides a one-deep TX holding buffer with a ready/load handshake, and a one-cycle RX valid strobe toward the slave register file.

Parameters:
DATA_WIDTH, 8, bits per SPI frame
SYNC_STAGES, 2, flip-flop depth of the pin synchronizers (minimum 2)

Ports:
clk  input  1  system clock; must be at least 4x the SCK frequency
rst  input  1  asynchronous, active-high reset
SCK_in  input  1  SPI clock from the master (asynchronous)
SS_n  input  1  slave select, active low (asynchronous)
MOSI  input  1  master-out data (asynchronous)
CPOL  input  1  clock polarity; static while SS_n is low
CPHA  input  1  clock phase; static while SS_n is low
LSBFE  input  1  1 = LSB first, 0 = MSB first
TX_data  input  DATA_WIDTH  byte to transmit
TX_load  input  1  write strobe for TX_data; accepted only when TX_ready=1
TX_ready  output  1  TX holding buffer empty
MISO  output  1  slave-out data
MISO_oe  output  1  MISO output enable; equals the synchronized ~SS_n
RX_data  output  DATA_WIDTH  last complete received byte
RX_valid  output  1  one-cycle strobe when RX_data updates
underrun  output  1  one-cycle pulse when a frame starts with the TX buffer empty
busy  output  1  high in the ACTIVE state

Behaviour:
- Reset values: TX_ready=1, MISO=0, MISO_oe=0, RX_data=0, RX_valid=0, underrun=0, busy=0. Synchronizers reset to SCK=CPOL, SS_n=1, MOSI=0. Bit counter and shift registers reset to 0. State = IDLE.
- Edge detection on the synchronized SCK, using a registered previous value:
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
  - SCK edges are ignored in IDLE.
- State machine, 2 states:
  - IDLE -> ACTIVE on the synchronized SS_n falling. That cycle: bit_cnt=0, tx_shift loaded from the holding buffer, TX_ready set to 1. If the buffer is empty, tx_shift=all ones and underrun pulses.
  - ACTIVE -> IDLE on synchronized SS_n high. Any partial frame is discarded with no RX_valid. bit_cnt is cleared. The holding buffer is preserved.
- MISO = LSBFE ? tx_shift[0] : tx_shift[DATA_WIDTH-1], gated to 0 when MISO_oe=0.
- Sample edge: MOSI is shifted into rx_shift at the end selected by LSBFE, and bit_cnt increments.
  - When bit_cnt reaches DATA_WIDTH: RX_data <= completed word, RX_valid=1 for exactly one cycle, bit_cnt wraps to 0.
- Shift edge: tx_shift shifts by one, toward MSB-first or LSB-first per LSBFE. Exceptions:
  - CPHA=1: the first leading edge of each frame does not shift; the first bit is already presented.
  - Frame boundary with SS_n held low (back-to-back frames): tx_shift reloads from the holding buffer instead of shifting. With the buffer empty it loads all ones and underrun pulses.
    - CPHA=0: reload on the trailing edge after the DATA_WIDTH-th sample.
    - CPHA=1: reload in the cycle bit_cnt wraps.
- TX handshake:
  - TX_load while TX_ready=1 captures TX_data and clears TX_ready in the next cycle.
  - TX_load while TX_ready=0 is ignored.
  - If TX_load and a reload happen in the same cycle, the reload takes the old buffer content, and the new data is captured with TX_ready=0.
- Latency: RX_valid asserts SYNC_STAGES+1 clk cycles after the final sample edge at the pin. MISO updates SYNC_STAGES+1 clk cycles after a shift edge.
- busy=1 exactly while in ACTIVE.
- Asynchronous rst mid-frame immediately returns every output to its reset value.

Test Plan:
- Mode 0, MSB first: TX_load 0xA5, SS_n low, master sends 0x3C with 8 SCK cycles (SCK period 8 clk) -> MISO bits 1,0,1,0,0,1,0,1; RX_data=0x3C; RX_valid high for exactly 1 cycle; TX_ready=1 after SS_n fall.
- Mode 3 (CPOL=1, CPHA=1), LSBFE=1: TX 0x81, master sends 0x0F -> MISO bits 1,0,0,0,0,0,0,1 on trailing-edge samples; RX_data=0x0F.
- Back-to-back frames in mode 1: TX 0x11, then TX_load 0x22 during frame 1, SS_n held low for 16 SCK -> MISO frames 0x11 then 0x22; two RX_valid pulses; no underrun.
- Underrun: SS_n falls with TX_ready=1 -> underrun pulses 1 cycle; MISO frame=0xFF; RX still captured correctly.
- Abort: SS_n rises after 5 bits in mode 0 -> no RX_valid; busy=0; RX_data unchanged; next full frame 0x5A received correctly.
- Reset mid-frame: assert rst after 3 bits -> all outputs at reset values in the same cycle; after release, frame 0xC3 received correctly.
